// File: rtl/sync_fifo_read_counter.sv
// sync_fifo_read_counter: read-side pointer, empty/occupancy and underflow logic of a single-clock FIFO
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   read_enable         - consumer read request
//   write_pointer_gray  - Gray write pointer from the write side
//   empty               - read pointer equals write pointer (including wrap bit)
//   read_enable_out     - read request qualified by not-empty; strobes the RAM read port
//   read_pointer        - RAM read address
//   read_pointer_gray   - registered Gray read pointer for the write side's full flag
//   fill_count          - occupancy, 0..2**ADDR_WIDTH
//   underflow           - sticky, set by a read request while empty
module sync_fifo_read_counter #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH:0]   write_pointer_gray,
    output logic                  empty,
    output logic                  read_enable_out,
    output logic [ADDR_WIDTH-1:0] read_pointer,
    output logic [ADDR_WIDTH:0]   read_pointer_gray,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  underflow
);
    logic [ADDR_WIDTH:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_bin;
    logic                underflow_q, underflow_d;
    always_comb begin
        wr_bin = '0;
        // binary bit i is the XOR of all Gray bits at and above i
        for (int i = 0; i <= ADDR_WIDTH; i++) wr_bin[i] = ^(write_pointer_gray >> i);
        empty           = rd_gray_q == write_pointer_gray;
        read_enable_out = read_enable & ~empty;
        rd_bin_d        = read_enable_out ? rd_bin_q + 1'b1 : rd_bin_q;
        rd_gray_d       = rd_bin_d ^ (rd_bin_d >> 1);
        underflow_d     = underflow_q | (read_enable & empty);
        fill_count      = wr_bin - rd_bin_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            underflow_q <= underflow_d;
        end
    end
    assign read_pointer      = rd_bin_q[ADDR_WIDTH-1:0];
    assign read_pointer_gray = rd_gray_q;
    assign underflow         = underflow_q;
endmodule

// File: tb/tb_sync_fifo_read_counter.sv
// tb_sync_fifo_read_counter: randomized and directed checks of the FIFO read counter against a count-based model
module tb_sync_fifo_read_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       read_enable = 1'b0;
    logic [3:0] write_pointer_gray = '0;
    logic       empty, read_enable_out, underflow;
    logic [2:0] read_pointer;
    logic [3:0] read_pointer_gray, fill_count;

    int errors = 0;
    int checks = 0;
    // model: total words written / read since reset, plus sticky underflow
    int wr_n = 0;
    int rd_n = 0;
    bit uf = 0;

    sync_fifo_read_counter #(.ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .read_enable(read_enable),
        .write_pointer_gray(write_pointer_gray), .empty(empty),
        .read_enable_out(read_enable_out), .read_pointer(read_pointer),
        .read_pointer_gray(read_pointer_gray), .fill_count(fill_count),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input bit re, input bit winc);
        @(negedge clk);
        read_enable = re;
        if (winc) begin
            wr_n++;
            write_pointer_gray = gray(wr_n);
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && read_enable) begin
            if (wr_n != rd_n) rd_n++;
            else uf = 1;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        read_enable = 1'b0;
        write_pointer_gray = '0;
        wr_n = 0; rd_n = 0; uf = 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write_pointer_gray = '0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (read_pointer !== 3'd0) begin errors++; $display("FAIL reset_rp: got %0h want 0", read_pointer); end
        checks++; if (read_pointer_gray !== 4'd0) begin errors++; $display("FAIL reset_rpg: got %0h want 0", read_pointer_gray); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_uf: got %b want 0", underflow); end
        release_reset();
    endtask

    task automatic test_empty_read();
        drive(1, 0);
        checks++; if (read_enable_out !== 1'b0) begin errors++; $display("FAIL empty_reo: got %b want 0", read_enable_out); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0);
            checks++; if (read_pointer !== 3'd0) begin errors++; $display("FAIL empty_rp: got %0h want 0", read_pointer); end
            checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL empty_uf: got %b want 1", underflow); end
            tick();
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin drive(0, 1); tick(); end
        drive(0, 0);
        checks++; if (fill_count !== 4'd8) begin errors++; $display("FAIL fill_count8: got %0d want 8", fill_count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", empty); end
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0);
            checks++; if (read_pointer !== 3'(i)) begin errors++; $display("FAIL drain_rp: got %0d want %0d", read_pointer, i); end
            checks++; if (read_enable_out !== 1'b1) begin errors++; $display("FAIL drain_reo: got %b want 1", read_enable_out); end
            tick();
        end
        drive(0, 0);
        checks++; if (read_pointer_gray !== 4'b1100) begin errors++; $display("FAIL drain_rpg: got %0h want c", read_pointer_gray); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b want 1", empty); end
        checks++; if (fill_count !== 4'd0) begin errors++; $display("FAIL drain_fill: got %0d want 0", fill_count); end
        tick();
    endtask

    task automatic test_wrap();
        logic [3:0] seq [17];
        logic [3:0] prev;
        seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        async_reset();
        release_reset();
        prev = 4'h0;
        for (int i = 0; i < 16; i++) begin
            drive(0, 1); tick();
            drive(1, 0); tick();
            drive(0, 0);
            checks++; if (read_pointer_gray !== seq[i+1]) begin errors++; $display("FAIL wrap_rpg[%0d]: got %0h want %0h", i, read_pointer_gray, seq[i+1]); end
            checks++; if ($countones(read_pointer_gray ^ prev) != 1) begin errors++; $display("FAIL wrap_onebit[%0d]: got %0h after %0h want one bit change", i, read_pointer_gray, prev); end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty[%0d]: got %b want 1", i, empty); end
            prev = read_pointer_gray;
            tick();
        end
    endtask

    task automatic test_simultaneous();
        drive(0, 1); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1); tick();
            drive(0, 0);
            checks++; if (fill_count !== 4'd1) begin errors++; $display("FAIL simul_fill[%0d]: got %0d want 1", i, fill_count); end
            checks++; if (empty !== 1'b0) begin errors++; $display("FAIL simul_empty[%0d]: got %b want 0", i, empty); end
            tick();
        end
    endtask

    task automatic test_random();
        bit re, wi;
        for (int i = 0; i < 400; i++) begin
            re = 1'($urandom_range(0, 1));
            wi = (wr_n - rd_n < 8) && ($urandom_range(0, 99) < 55);
            drive(re, wi);
            checks++;
            if (fill_count !== 4'(wr_n - rd_n) || empty !== (wr_n == rd_n) ||
                read_enable_out !== (re && wr_n != rd_n) || read_pointer !== 3'(rd_n % 8) ||
                read_pointer_gray !== gray(rd_n) || underflow !== uf) begin
                errors++;
                $display("FAIL random[%0d]: got fill=%0d empty=%b reo=%b rp=%0d rpg=%0h uf=%b want fill=%0d empty=%b reo=%b rp=%0d rpg=%0h uf=%b",
                         i, fill_count, empty, read_enable_out, read_pointer, read_pointer_gray, underflow,
                         wr_n - rd_n, wr_n == rd_n, re && wr_n != rd_n, rd_n % 8, gray(rd_n), uf);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        async_reset();
        release_reset();
        drive(1, 0); tick();
        for (int i = 0; i < 7; i++) begin drive(0, 1); tick(); end
        for (int i = 0; i < 2; i++) begin drive(1, 0); tick(); end
        drive(0, 0);
        checks++; if (fill_count !== 4'd5 || underflow !== 1'b1) begin errors++; $display("FAIL arst_setup: got fill=%0d uf=%b want fill=5 uf=1", fill_count, underflow); end
        async_reset();
        checks++; if (read_pointer !== 3'd0) begin errors++; $display("FAIL arst_rp: got %0d want 0", read_pointer); end
        checks++; if (read_pointer_gray !== 4'd0) begin errors++; $display("FAIL arst_rpg: got %0h want 0", read_pointer_gray); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL arst_uf: got %b want 0", underflow); end
        checks++; if (empty !== 1'b1 || fill_count !== 4'd0) begin errors++; $display("FAIL arst_flags: got empty=%b fill=%0d want empty=1 fill=0", empty, fill_count); end
        release_reset();
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
